v_query_sched: RTL and testbench

Query-side scheduler for the shared state-table read port. It buffers host list queries and arbitrates each cycle between the update pipeline's S0 read and a query issue into `v_pipe_query`. Update reads have priority, with a starvation guard that periodically forces a query through. The block sits between the host query bus and `v_pipe_query`, and tracks each issued query into S1 to return a qualified response.

---
 rtl/v_query_sched_if.sv | 48 ++++
 rtl/v_query_sched.sv | 170 +++++++++++++++++
 tb/tb_v_query_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_query_sched_if.sv
// v_query_sched_if: shared types (v_pkg) and the bundled host-query,
// update-grant, query-pipe issue and S1 response signals of v_query_sched.
// The scheduler takes the slave modport; the host/pipe side takes master.

package v_pkg;
    typedef logic [15:0] id_t;
    typedef logic [3:0]  level_t;
    typedef logic [7:0]  listsize_t;
endpackage

interface v_query_sched_if;
    import v_pkg::*;

    logic      i_qry_vld;
    id_t       i_qry_prod_id;
    level_t    i_qry_level;
    logic      o_qry_rdy;
    logic      i_upd_vld;
    logic      o_upd_rdy;
    logic      o_rd_sel;
    logic      o_lut_vld;
    id_t       o_lut_prod_id;
    level_t    o_lut_level;
    logic      i_lut_error;
    listsize_t i_lut_listsize;
    logic      o_rsp_vld;
    logic      o_rsp_busy;

    modport slave (
        input  i_qry_vld, i_qry_prod_id, i_qry_level,
        output o_qry_rdy,
        input  i_upd_vld,
        output o_upd_rdy, o_rd_sel,
        output o_lut_vld, o_lut_prod_id, o_lut_level,
        input  i_lut_error, i_lut_listsize,
        output o_rsp_vld, o_rsp_busy
    );

    modport master (
        output i_qry_vld, i_qry_prod_id, i_qry_level,
        input  o_qry_rdy,
        output i_upd_vld,
        input  o_upd_rdy, o_rd_sel,
        input  o_lut_vld, o_lut_prod_id, o_lut_level,
        output i_lut_error, i_lut_listsize,
        input  o_rsp_vld, o_rsp_busy
    );
endinterface

// File: rtl/v_query_sched.sv
// v_query_sched: buffers host list queries in a 2-entry FIFO and arbitrates
// the shared state-table read port between update S0 reads and query issues.
// Updates have priority; a starvation counter forces a waiting query through
// after STARVE_MAX lost cycles. Issued queries are tracked into S1 to qualify
// the response. Optional busy-retry path: define V_QRY_SCHED_RETRY_EN.

module v_query_sched #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned RETRY_MAX  = 3
) (
    input logic            clk,
    input logic            rst_n,
    v_query_sched_if.slave q
);
    import v_pkg::*;

    typedef struct packed {
        id_t    id;
        level_t level;
    } entry_t;

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || RETRY_MAX > 14) begin : g_param_check
        $error("v_query_sched: STARVE_MAX must be 1..15 and RETRY_MAX 0..14");
    end

    entry_t     fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    entry_t     cand;
    logic       cand_vld;
    logic       starve_force;
    logic       qry_grant;
    logic [3:0] starve_cnt;

    logic       s1_vld;
    logic       busy;

`ifdef V_QRY_SCHED_RETRY_EN
    entry_t     s1_ent;
    logic [3:0] s1_retry_cnt;
    logic       retry_vld;
    entry_t     retry_ent;
    logic [3:0] retry_cnt;
    logic       retry_free;
    logic       retry_take;
`endif

    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign push       = q.i_qry_vld & ~fifo_full;

    // Candidate selection: a pending retry preempts the FIFO head.
    always_comb begin
        cand_vld = ~fifo_empty;
        cand     = fifo_mem[rd_ptr];
`ifdef V_QRY_SCHED_RETRY_EN
        if (retry_vld) begin
            cand_vld = 1'b1;
            cand     = retry_ent;
        end
`endif
    end

    assign starve_force = (starve_cnt == 4'(STARVE_MAX));
    assign qry_grant    = cand_vld & (~q.i_upd_vld | starve_force);

`ifdef V_QRY_SCHED_RETRY_EN
    assign pop = qry_grant & ~retry_vld;
`else
    assign pop = qry_grant;
`endif

    // FIFO storage; contents need no reset since occupancy qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{id: q.i_qry_prod_id, level: q.i_qry_level};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Starvation counter: counts cycles a waiting candidate loses to updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (qry_grant || !cand_vld) begin
            starve_cnt <= '0;
        end else if (!starve_force) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // S1 tracking of the query issued last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= qry_grant;
        end
    end

    assign busy = q.i_lut_error & (q.i_lut_listsize != '0);

`ifdef V_QRY_SCHED_RETRY_EN
    // A second busy query may land in S1 while the retry slot still holds an
    // unissued entry; that query is answered busy instead of overwriting it.
    assign retry_free = ~retry_vld | qry_grant;
    assign retry_take = s1_vld & busy & (s1_retry_cnt < 4'(RETRY_MAX)) & retry_free;

    // S1 copy of the issued entry and its attempt count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ent       <= '0;
            s1_retry_cnt <= '0;
        end else if (qry_grant) begin
            s1_ent       <= cand;
            s1_retry_cnt <= retry_vld ? retry_cnt : 4'd0;
        end
    end

    // Single-entry retry register fed by busy S1 results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_vld <= 1'b0;
            retry_ent <= '0;
            retry_cnt <= '0;
        end else if (retry_take) begin
            retry_vld <= 1'b1;
            retry_ent <= s1_ent;
            retry_cnt <= s1_retry_cnt + 4'd1;
        end else if (qry_grant && retry_vld) begin
            retry_vld <= 1'b0;
        end
    end

    assign q.o_rsp_vld = s1_vld & ~retry_take;
`else
    assign q.o_rsp_vld = s1_vld;
`endif

    assign q.o_rsp_busy    = busy & q.o_rsp_vld;
    assign q.o_qry_rdy     = ~fifo_full;
    assign q.o_upd_rdy     = q.i_upd_vld & ~qry_grant;
    assign q.o_rd_sel      = qry_grant;
    assign q.o_lut_vld     = qry_grant;
    assign q.o_lut_prod_id = cand.id;
    assign q.o_lut_level   = cand.level;

endmodule

// File: tb/tb_v_query_sched.sv
// tb_v_query_sched: directed sequences for idle issue, starvation, FIFO full
// and reset, plus a table of S1 result vectors. Issues are checked in order
// against a queue of expected {id, level} filled when queries are pushed.

module tb_v_query_sched;
    import v_pkg::*;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned RETRY_MAX  = 3;
`ifdef V_QRY_SCHED_RETRY_EN
    localparam int BUSY_ISSUES = RETRY_MAX + 1;
`else
    localparam int BUSY_ISSUES = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    v_query_sched_if q();

    v_query_sched #(.STARVE_MAX(STARVE_MAX), .RETRY_MAX(RETRY_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q)
    );

    typedef struct packed {
        id_t    id;
        level_t level;
    } exp_t;

    typedef struct {
        logic      err;
        listsize_t size;
        logic      exp_busy;
        int        exp_issues;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_issue_q[$];
    exp_t mon_e;
    int   issue_cnt = 0;
    int   rsp_cnt = 0;
    int   rsp_busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        q.i_qry_vld      = 1'b0;
        q.i_qry_prod_id  = '0;
        q.i_qry_level    = '0;
        q.i_upd_vld      = 1'b0;
        q.i_lut_error    = 1'b0;
        q.i_lut_listsize = 8'd4;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_issue_q.delete();
        tick();
    endtask

    task automatic drive_query(input id_t id, input level_t lvl);
        q.i_qry_vld     = 1'b1;
        q.i_qry_prod_id = id;
        q.i_qry_level   = lvl;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_qry_rdy"},  q.o_qry_rdy,  1);
        chk({tag, "_upd_rdy"},  q.o_upd_rdy,  0);
        chk({tag, "_rd_sel"},   q.o_rd_sel,   0);
        chk({tag, "_lut_vld"},  q.o_lut_vld,  0);
        chk({tag, "_rsp_vld"},  q.o_rsp_vld,  0);
        chk({tag, "_rsp_busy"}, q.o_rsp_busy, 0);
    endtask

    // Issue and response monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q.o_lut_vld === 1'b1) begin
                issue_cnt++;
                if (exp_issue_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got id %0h expected no issue at %0t",
                             q.o_lut_prod_id, $time);
                end else begin
                    mon_e = exp_issue_q.pop_front();
                    chk("issue_id",    q.o_lut_prod_id, mon_e.id);
                    chk("issue_level", q.o_lut_level,   mon_e.level);
                end
            end
            if (q.o_rsp_vld === 1'b1) begin
                rsp_cnt++;
                if (q.o_rsp_busy === 1'b1) rsp_busy_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   base_iss;
        int   base_rsp;
        int   base_busy;

        vecs[0] = '{err: 1'b0, size: 8'd5,   exp_busy: 1'b0, exp_issues: 1};
        vecs[1] = '{err: 1'b1, size: 8'd0,   exp_busy: 1'b0, exp_issues: 1};
        vecs[2] = '{err: 1'b0, size: 8'd0,   exp_busy: 1'b0, exp_issues: 1};
        vecs[3] = '{err: 1'b1, size: 8'd3,   exp_busy: 1'b1, exp_issues: BUSY_ISSUES};
        vecs[4] = '{err: 1'b1, size: 8'hff,  exp_busy: 1'b1, exp_issues: BUSY_ISSUES};

        do_reset();
        at_neg();
        chk_reset_outputs("rst");
        tick();

        // Idle update: push-to-empty issues one cycle later, response after that.
        drive_query(16'd5, 4'd2);
        exp_issue_q.push_back('{id: 16'd5, level: 4'd2});
        at_neg();
        chk("idle_rdy_c0", q.o_qry_rdy, 1);
        chk("idle_no_bypass", q.o_lut_vld, 0);
        tick();
        q.i_qry_vld = 1'b0;
        at_neg();
        chk("idle_lut_vld_c1", q.o_lut_vld, 1);
        chk("idle_rd_sel_c1",  q.o_rd_sel,  1);
        chk("idle_rsp_c1",     q.o_rsp_vld, 0);
        chk("idle_upd_rdy_c1", q.o_upd_rdy, 0);
        tick();
        at_neg();
        chk("idle_rsp_c2",      q.o_rsp_vld,  1);
        chk("idle_rsp_busy_c2", q.o_rsp_busy, 0);
        chk("idle_lut_vld_c2",  q.o_lut_vld,  0);
        tick();

        // Starvation: update holds the port for STARVE_MAX cycles, then a forced query.
        q.i_upd_vld = 1'b1;
        drive_query(16'd9, 4'd1);
        exp_issue_q.push_back('{id: 16'd9, level: 4'd1});
        at_neg();
        chk("starve_upd_c0", q.o_upd_rdy, 1);
        tick();
        q.i_qry_vld = 1'b0;
        for (int c = 1; c <= STARVE_MAX; c++) begin
            at_neg();
            chk("starve_lose_lut", q.o_lut_vld, 0);
            chk("starve_lose_upd", q.o_upd_rdy, 1);
            tick();
        end
        at_neg();
        chk("starve_force_lut", q.o_lut_vld, 1);
        chk("starve_force_upd", q.o_upd_rdy, 0);
        tick();
        drive_query(16'd10, 4'd3);
        exp_issue_q.push_back('{id: 16'd10, level: 4'd3});
        at_neg();
        chk("starve_after_upd", q.o_upd_rdy, 1);
        chk("starve_after_rsp", q.o_rsp_vld, 1);
        tick();
        q.i_qry_vld = 1'b0;
        for (int c = 1; c <= STARVE_MAX; c++) begin
            at_neg();
            chk("starve2_lose_lut", q.o_lut_vld, 0);
            tick();
        end
        at_neg();
        chk("starve2_force_lut", q.o_lut_vld, 1);
        tick();
        q.i_upd_vld = 1'b0;
        repeat (3) tick();

        // FIFO full under continuous update traffic.
        q.i_upd_vld = 1'b1;
        drive_query(16'h11, 4'd1);
        exp_issue_q.push_back('{id: 16'h11, level: 4'd1});
        at_neg();
        chk("full_rdy_a", q.o_qry_rdy, 1);
        tick();
        drive_query(16'h22, 4'd2);
        exp_issue_q.push_back('{id: 16'h22, level: 4'd2});
        at_neg();
        chk("full_rdy_b", q.o_qry_rdy, 1);
        tick();
        drive_query(16'h33, 4'd3);
        for (int c = 2; c <= 5; c++) begin
            at_neg();
            chk("full_rdy_blocked", q.o_qry_rdy, 0);
            chk("full_lut_vld", q.o_lut_vld, (c == 5) ? 1 : 0);
            tick();
        end
        at_neg();
        chk("full_rdy_free", q.o_qry_rdy, 1);
        exp_issue_q.push_back('{id: 16'h33, level: 4'd3});
        tick();
        q.i_qry_vld = 1'b0;
        q.i_upd_vld = 1'b0;
        repeat (5) tick();
        chk("full_drained", exp_issue_q.size(), 0);

        // S1 result vectors.
        for (int i = 0; i < 5; i++) begin
            base_iss  = issue_cnt;
            base_rsp  = rsp_cnt;
            base_busy = rsp_busy_cnt;
            q.i_lut_error    = vecs[i].err;
            q.i_lut_listsize = vecs[i].size;
            drive_query(16'h100 + 16'(i), 4'(i));
            for (int k = 0; k < vecs[i].exp_issues; k++)
                exp_issue_q.push_back('{id: 16'h100 + 16'(i), level: 4'(i)});
            tick();
            q.i_qry_vld = 1'b0;
            repeat (20) tick();
            chk("vec_issues",   issue_cnt - base_iss,     vecs[i].exp_issues);
            chk("vec_rsp",      rsp_cnt - base_rsp,       1);
            chk("vec_rsp_busy", rsp_busy_cnt - base_busy, vecs[i].exp_busy);
        end
        idle_inputs();
        tick();

        // Reset mid-operation with a response in S1 and queued host queries.
        q.i_upd_vld = 1'b1;
        drive_query(16'h41, 4'd1);
        exp_issue_q.push_back('{id: 16'h41, level: 4'd1});
        tick();
        drive_query(16'h42, 4'd2);
        tick();
        drive_query(16'h43, 4'd3);
        repeat (4) tick();
        #1;
        chk("rst_pre_rsp", q.o_rsp_vld, 1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        exp_issue_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        base_iss = issue_cnt;
        base_rsp = rsp_cnt;
        repeat (8) tick();
        chk("rst_no_issue", issue_cnt - base_iss, 0);
        chk("rst_no_rsp",   rsp_cnt - base_rsp,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
